// File: rtl/seq_bank1_pkg.sv
// Shared encodings for the bank1 descriptor slot table: slot status values and write field codes.
package seq_bank1_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PENDING = 2'b01;
    localparam logic [1:0] ST_RUNNING = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

    localparam logic [2:0] FLD_SRC_ADDR = 3'd0;
    localparam logic [2:0] FLD_SRC_SIZE = 3'd1;
    localparam logic [2:0] FLD_DST_ADDR = 3'd2;
    localparam logic [2:0] FLD_DST_SIZE = 3'd3;
    localparam logic [2:0] FLD_STATUS   = 3'd4;

endpackage

// File: rtl/seq_bank1_slot.sv
// One bank1 descriptor slot: field registers, status FSM and saturating cycle profile counter.
module seq_bank1_slot
    import seq_bank1_pkg::*;
#(
    parameter int SRC_ADDR_W = 32,
    parameter int SRC_SIZE_W = 26,
    parameter int DST_ADDR_W = 32,
    parameter int DST_SIZE_W = 26,
    parameter int PROFILE_W  = 32,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_sel_i,
    input  logic [2:0]            wr_field_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic                  start_i,
    input  logic                  finish_i,
    output logic [SRC_ADDR_W-1:0] src_addr_o,
    output logic [SRC_SIZE_W-1:0] src_size_o,
    output logic [DST_ADDR_W-1:0] dst_addr_o,
    output logic [DST_SIZE_W-1:0] dst_size_o,
    output logic [1:0]            status_o,
    output logic [PROFILE_W-1:0]  profile_o,
    output logic                  wr_reject_o
);

    logic [SRC_ADDR_W-1:0] src_addr_q, src_addr_d;
    logic [SRC_SIZE_W-1:0] src_size_q, src_size_d;
    logic [DST_ADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic [DST_SIZE_W-1:0] dst_size_q, dst_size_d;
    logic [1:0]            status_q, status_d;
    logic [PROFILE_W-1:0]  profile_q, profile_d;
    logic                  running;

    assign running = (status_q == ST_RUNNING);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        src_addr_d  = src_addr_q;
        src_size_d  = src_size_q;
        dst_addr_d  = dst_addr_q;
        dst_size_d  = dst_size_q;
        status_d    = status_q;
        profile_d   = profile_q;
        wr_reject_o = 1'b0;

        if (wr_sel_i) begin
            case (wr_field_i)
                FLD_SRC_ADDR, FLD_SRC_SIZE, FLD_DST_ADDR, FLD_DST_SIZE: begin
                    if (running) begin
                        wr_reject_o = 1'b1;
                    end else begin
                        status_d = ST_PENDING;
                        case (wr_field_i)
                            FLD_SRC_ADDR: src_addr_d = wr_data_i[SRC_ADDR_W-1:0];
                            FLD_SRC_SIZE: src_size_d = wr_data_i[SRC_SIZE_W-1:0];
                            FLD_DST_ADDR: dst_addr_d = wr_data_i[DST_ADDR_W-1:0];
                            default:      dst_size_d = wr_data_i[DST_SIZE_W-1:0];
                        endcase
                    end
                end
                FLD_STATUS: begin
                    if (running) wr_reject_o = 1'b1;
                    else         status_d    = wr_data_i[1:0];
                end
                default: ;
            endcase
        end

        // Sequencer events are evaluated after the write so their status change wins.
        if (running && profile_q != '1) profile_d = profile_q + 1'b1;
        if (start_i) begin
            if (status_q == ST_PENDING) begin
                status_d  = ST_RUNNING;
                profile_d = '0;
            end
        end else if (finish_i && running) begin
            status_d = ST_DONE;
        end
    end

    // NOTE: the slot registers are a handful of flops, not a RAM, so all of them take the reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_addr_q <= '0;
            src_size_q <= '0;
            dst_addr_q <= '0;
            dst_size_q <= '0;
            status_q   <= ST_IDLE;
            profile_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            src_addr_q <= src_addr_d;
            src_size_q <= src_size_d;
            dst_addr_q <= dst_addr_d;
            dst_size_q <= dst_size_d;
            status_q   <= status_d;
            profile_q  <= profile_d;
        end
    end

    assign src_addr_o = src_addr_q;
    assign src_size_o = src_size_q;
    assign dst_addr_o = dst_addr_q;
    assign dst_size_o = dst_size_q;
    assign status_o   = status_q;
    assign profile_o  = profile_q;

endmodule

// File: rtl/seq_bank1_slot_table.sv
// Bank1 descriptor store: decodes write/sequencer ports onto per-slot enables and muxes the read port.
module seq_bank1_slot_table
    import seq_bank1_pkg::*;
#(
    parameter int BANK1_INDEX_WIDTH    = 3,
    parameter int BANK1_SRC_ADDR_WIDTH = 32,
    parameter int BANK1_SRC_SIZE_WIDTH = 26,
    parameter int BANK1_DST_ADDR_WIDTH = 32,
    parameter int BANK1_DST_SIZE_WIDTH = 26,
    parameter int BANK1_STATUS_WIDTH   = 2,
    parameter int BANK1_PROFILE_WIDTH  = 32,
    parameter int DATA_WIDTH           = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [BANK1_INDEX_WIDTH-1:0]    wr_index,
    input  logic [2:0]                      wr_field,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            wr_err,
    input  logic                            rd_req,
    input  logic [BANK1_INDEX_WIDTH-1:0]    rd_index,
    output logic [BANK1_SRC_ADDR_WIDTH-1:0] rd_src_addr,
    output logic [BANK1_SRC_SIZE_WIDTH-1:0] rd_src_size,
    output logic [BANK1_DST_ADDR_WIDTH-1:0] rd_dst_addr,
    output logic [BANK1_DST_SIZE_WIDTH-1:0] rd_dst_size,
    output logic [BANK1_STATUS_WIDTH-1:0]   rd_status,
    output logic [BANK1_PROFILE_WIDTH-1:0]  rd_profile,
    output logic                            rd_ready,
    input  logic [BANK1_INDEX_WIDTH-1:0]    seq_index,
    input  logic                            seq_start,
    input  logic                            seq_finish,
    output logic [BANK1_STATUS_WIDTH-1:0]   seq_slot_status
);

    localparam int SLOTS = 2 ** BANK1_INDEX_WIDTH;

    logic [BANK1_SRC_ADDR_WIDTH-1:0] src_addr_a [SLOTS];
    logic [BANK1_SRC_SIZE_WIDTH-1:0] src_size_a [SLOTS];
    logic [BANK1_DST_ADDR_WIDTH-1:0] dst_addr_a [SLOTS];
    logic [BANK1_DST_SIZE_WIDTH-1:0] dst_size_a [SLOTS];
    logic [BANK1_STATUS_WIDTH-1:0]   status_a   [SLOTS];
    logic [BANK1_PROFILE_WIDTH-1:0]  profile_a  [SLOTS];
    logic [SLOTS-1:0]                reject_vec;
    logic                            wr_err_q, wr_err_d;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        seq_bank1_slot #(
            .SRC_ADDR_W (BANK1_SRC_ADDR_WIDTH),
            .SRC_SIZE_W (BANK1_SRC_SIZE_WIDTH),
            .DST_ADDR_W (BANK1_DST_ADDR_WIDTH),
            .DST_SIZE_W (BANK1_DST_SIZE_WIDTH),
            .PROFILE_W  (BANK1_PROFILE_WIDTH),
            .DATA_W     (DATA_WIDTH)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .wr_sel_i    (wr_en && (wr_index == BANK1_INDEX_WIDTH'(g))),
            .wr_field_i  (wr_field),
            .wr_data_i   (wr_data),
            .start_i     (seq_start && (seq_index == BANK1_INDEX_WIDTH'(g))),
            .finish_i    (seq_finish && (seq_index == BANK1_INDEX_WIDTH'(g))),
            .src_addr_o  (src_addr_a[g]),
            .src_size_o  (src_size_a[g]),
            .dst_addr_o  (dst_addr_a[g]),
            .dst_size_o  (dst_size_a[g]),
            .status_o    (status_a[g]),
            .profile_o   (profile_a[g]),
            .wr_reject_o (reject_vec[g])
        );
    end

    assign wr_err_d = |reject_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wr_err_q <= 1'b0;
        else        wr_err_q <= wr_err_d;
    end

    assign wr_err = wr_err_q;

    // Read port shows registered contents, so a same-cycle update is seen only after the edge.
    always_comb begin
        rd_src_addr = '0;
        rd_src_size = '0;
        rd_dst_addr = '0;
        rd_dst_size = '0;
        rd_status   = '0;
        rd_profile  = '0;
        if (rd_req) begin
            rd_src_addr = src_addr_a[rd_index];
            rd_src_size = src_size_a[rd_index];
            rd_dst_addr = dst_addr_a[rd_index];
            rd_dst_size = dst_size_a[rd_index];
            rd_status   = status_a[rd_index];
            rd_profile  = profile_a[rd_index];
        end
    end

    assign rd_ready        = rd_req;
    assign seq_slot_status = status_a[seq_index];

endmodule

// File: tb/tb_seq_bank1_slot_table.sv
// Bench for the bank1 slot table: a default build plus a 4-bit profile build share the same stimulus.
module tb_seq_bank1_slot_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_index;
    logic [2:0]  wr_field;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [2:0]  rd_index;
    logic [2:0]  seq_index;
    logic        seq_start;
    logic        seq_finish;

    logic        wr_err, rd_ready;
    logic [31:0] rd_src_addr, rd_dst_addr, rd_profile;
    logic [25:0] rd_src_size, rd_dst_size;
    logic [1:0]  rd_status, seq_slot_status;

    logic        s_wr_err, s_rd_ready;
    logic [31:0] s_rd_src_addr, s_rd_dst_addr;
    logic [25:0] s_rd_src_size, s_rd_dst_size;
    logic [1:0]  s_rd_status, s_seq_slot_status;
    logic [3:0]  s_rd_profile;

    always #5 clk = ~clk;

    seq_bank1_slot_table dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_index(wr_index), .wr_field(wr_field), .wr_data(wr_data), .wr_err(wr_err),
        .rd_req(rd_req), .rd_index(rd_index),
        .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
        .rd_dst_addr(rd_dst_addr), .rd_dst_size(rd_dst_size),
        .rd_status(rd_status), .rd_profile(rd_profile), .rd_ready(rd_ready),
        .seq_index(seq_index), .seq_start(seq_start), .seq_finish(seq_finish),
        .seq_slot_status(seq_slot_status)
    );

    seq_bank1_slot_table #(.BANK1_PROFILE_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_index(wr_index), .wr_field(wr_field), .wr_data(wr_data), .wr_err(s_wr_err),
        .rd_req(rd_req), .rd_index(rd_index),
        .rd_src_addr(s_rd_src_addr), .rd_src_size(s_rd_src_size),
        .rd_dst_addr(s_rd_dst_addr), .rd_dst_size(s_rd_dst_size),
        .rd_status(s_rd_status), .rd_profile(s_rd_profile), .rd_ready(s_rd_ready),
        .seq_index(seq_index), .seq_start(seq_start), .seq_finish(seq_finish),
        .seq_slot_status(s_seq_slot_status)
    );

    typedef struct packed {
        logic        req;
        logic [31:0] sa;
        logic [25:0] ss;
        logic [31:0] da;
        logic [25:0] ds;
        logic [1:0]  st;
        logic [31:0] pf;
        logic [3:0]  spf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_sa [8];
    logic [25:0] m_ss [8];
    logic [31:0] m_da [8];
    logic [25:0] m_ds [8];
    logic [1:0]  m_st [8];
    int unsigned m_pf [8];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sa[i] = '0; m_ss[i] = '0; m_da[i] = '0; m_ds[i] = '0;
            m_st[i] = 2'b00; m_pf[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the model's view of the slot, then compare once the combinational read has settled.
    task automatic rd(input logic [2:0] idx, input logic req);
        exp_t e;
        int unsigned p;
        rd_req   = req;
        rd_index = idx;
        e        = '0;
        e.req    = req;
        if (req) begin
            p     = m_pf[idx];
            e.sa  = m_sa[idx];
            e.ss  = m_ss[idx];
            e.da  = m_da[idx];
            e.ds  = m_ds[idx];
            e.st  = m_st[idx];
            e.pf  = p;
            e.spf = (p > 15) ? 4'hF : p[3:0];
        end
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check($sformatf("slot%0d.rd_ready", idx), 64'(rd_ready), 64'(e.req));
        check($sformatf("slot%0d.src_addr", idx), 64'(rd_src_addr), 64'(e.sa));
        check($sformatf("slot%0d.src_size", idx), 64'(rd_src_size), 64'(e.ss));
        check($sformatf("slot%0d.dst_addr", idx), 64'(rd_dst_addr), 64'(e.da));
        check($sformatf("slot%0d.dst_size", idx), 64'(rd_dst_size), 64'(e.ds));
        check($sformatf("slot%0d.status", idx), 64'(rd_status), 64'(e.st));
        check($sformatf("slot%0d.profile", idx), 64'(rd_profile), 64'(e.pf));
        check($sformatf("slot%0d.profile4", idx), 64'(s_rd_profile), 64'(e.spf));
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [2:0] fld, input logic [31:0] data);
        wr_en = 1'b1; wr_index = idx; wr_field = fld; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic seq(input logic [2:0] idx, input logic start, input logic finish);
        seq_index = idx; seq_start = start; seq_finish = finish;
        tick();
        seq_start = 1'b0; seq_finish = 1'b0;
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_index = '0; wr_field = '0; wr_data = '0;
        rd_req = 1'b0; rd_index = '0; seq_index = '0; seq_start = 1'b0; seq_finish = 1'b0;
        model_reset();

        #12;
        rd(3'd0, 1'b1);
        #10 reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) rd(3'(i), 1'b1);
        tick();
        rd(3'd3, 1'b0);
        check("wr_err_idle", 64'(wr_err), 64'd0);
        check("seq_status_idle", 64'(seq_slot_status), 64'd0);

        // Field writes mark the slot PENDING; neighbours stay untouched.
        wr(3'd3, 3'd0, 32'h8000_0000);
        wr(3'd3, 3'd1, 32'h03FF_FFFF);
        m_sa[3] = 32'h8000_0000; m_ss[3] = 26'h3FF_FFFF; m_st[3] = 2'b01;
        check("wr_err_ok", 64'(wr_err), 64'd0);
        rd(3'd3, 1'b1);
        rd(3'd2, 1'b1);
        seq_index = 3'd3;
        #1 check("seq_status_pending", 64'(seq_slot_status), 64'd1);

        // Start slot3, try a rejected write during RUNNING, then a good write elsewhere.
        seq(3'd3, 1'b1, 1'b0);
        m_st[3] = 2'b10; m_pf[3] = 0;
        rd(3'd3, 1'b1);
        wr(3'd3, 3'd2, 32'hDEAD_BEEF);
        check("wr_err_running", 64'(wr_err), 64'd1);
        wr(3'd4, 3'd2, 32'h1234_5678);
        check("wr_err_pulse_end", 64'(wr_err), 64'd0);
        m_da[4] = 32'h1234_5678; m_st[4] = 2'b01; m_pf[3] = 2;
        rd(3'd3, 1'b1);
        rd(3'd4, 1'b1);
        repeat (7) tick();
        seq(3'd3, 1'b0, 1'b1);
        m_st[3] = 2'b11; m_pf[3] = 10;
        rd(3'd3, 1'b1);
        check("seq_status_done", 64'(seq_slot_status), 64'd3);
        repeat (5) tick();
        rd(3'd3, 1'b1);

        // Ignored events: start on DONE, finish on PENDING, reserved field codes.
        seq(3'd3, 1'b1, 1'b0);
        rd(3'd3, 1'b1);
        seq(3'd4, 1'b0, 1'b1);
        rd(3'd4, 1'b1);
        wr(3'd4, 3'd5, 32'hFFFF_FFFF);
        check("wr_err_reserved", 64'(wr_err), 64'd0);
        rd(3'd4, 1'b1);
        wr(3'd6, 3'd4, 32'h0000_0003);
        m_st[6] = 2'b11;
        check("wr_err_status_wr", 64'(wr_err), 64'd0);
        rd(3'd6, 1'b1);

        // Status write and start to the same PENDING slot: RUNNING wins.
        wr_en = 1'b1; wr_index = 3'd4; wr_field = 3'd4; wr_data = 32'h0;
        seq_index = 3'd4; seq_start = 1'b1;
        tick();
        wr_en = 1'b0; seq_start = 1'b0;
        m_st[4] = 2'b10; m_pf[4] = 0;
        rd(3'd4, 1'b1);
        seq(3'd4, 1'b0, 1'b1);
        m_st[4] = 2'b11; m_pf[4] = 1;
        rd(3'd4, 1'b1);

        // Start and finish together: only the start is honoured.
        wr(3'd7, 3'd3, 32'h0000_0155);
        m_ds[7] = 26'h155; m_st[7] = 2'b01;
        seq(3'd7, 1'b1, 1'b1);
        m_st[7] = 2'b10; m_pf[7] = 0;
        rd(3'd7, 1'b1);
        seq(3'd7, 1'b0, 1'b1);
        m_st[7] = 2'b11; m_pf[7] = 1;
        rd(3'd7, 1'b1);

        // Long run on slot5: the 4-bit build must saturate at 4'hF.
        wr(3'd5, 3'd0, 32'h0000_CAFE);
        m_sa[5] = 32'h0000_CAFE; m_st[5] = 2'b01;
        seq(3'd5, 1'b1, 1'b0);
        m_st[5] = 2'b10; m_pf[5] = 0;
        repeat (20) tick();
        m_pf[5] = 20;
        rd(3'd5, 1'b1);

        // Asynchronous reset while slot5 is RUNNING clears it without waiting for an edge.
        reset = 1'b0;
        #1;
        model_reset();
        rd(3'd5, 1'b1);
        rd(3'd3, 1'b1);
        check("wr_err_in_reset", 64'(wr_err), 64'd0);
        check("seq_status_reset", 64'(seq_slot_status), 64'd0);
        #2 reset = 1'b1;
        tick();
        rd(3'd5, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
